lv_fault_mgr: RTL and testbench

Parametrised low-voltage fault manager for the LV control unit. It takes ERR_NUM raw error flags and applies per-channel masking and a digital debounce filter. It records a sticky, write-1-clear status bit per channel and captures the first-failing channel index. A monitor FSM drives the fault, PWM-gate and interrupt outputs, and enforces a programmable hold-off before recovery. It sits between the register file / analog error sources and the top-level LV control FSM, which consumes o_fault and o_pwm_gate.

---
 rtl/lv_fault_pkg.sv | 14 +
 rtl/lv_fault_mgr_if.sv | 41 ++++
 rtl/lv_err_dbnc.sv | 35 +++
 rtl/lv_fault_mgr.sv | 118 +++++++++++
 tb/tb_lv_fault_mgr.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lv_fault_pkg.sv
// Shared types and widths for the LV fault manager: monitor FSM encoding and counter widths.
package lv_fault_pkg;

  localparam int FAULT_ST_W  = 2;
  localparam int FAULT_CNT_W = 8;

  typedef enum logic [FAULT_ST_W-1:0] {
    IDLE  = 2'd0,
    MON   = 2'd1,
    FAULT = 2'd2,
    HOLD  = 2'd3
  } fault_st_e;

endpackage

// File: rtl/lv_fault_mgr_if.sv
// Fault manager signal bundle: error sources / register controls in, status and fault requests out.
interface lv_fault_mgr_if
  import lv_fault_pkg::*;
#(
  parameter int ERR_NUM = 16,
  parameter int DBNC_W  = 4,
  parameter int HOLD_W  = 8
) ();

  localparam int ID_W = $clog2(ERR_NUM);

  logic                   i_mon_en;
  logic [ERR_NUM-1:0]     i_err_raw;
  logic [ERR_NUM-1:0]     i_err_mask;
  logic [ERR_NUM-1:0]     i_err_fatal;
  logic [DBNC_W-1:0]      i_dbnc_thr;
  logic [HOLD_W-1:0]      i_hold_cyc;
  logic [ERR_NUM-1:0]     i_err_clr;
  logic [ERR_NUM-1:0]     o_err_act;
  logic [ERR_NUM-1:0]     o_err_sticky;
  logic [ID_W-1:0]        o_first_id;
  logic                   o_first_vld;
  logic [FAULT_ST_W-1:0]  o_fst;
  logic                   o_fault;
  logic                   o_pwm_gate;
  logic                   o_intb_n;
  logic [FAULT_CNT_W-1:0] o_fault_cnt;

  modport master (
    output i_mon_en, i_err_raw, i_err_mask, i_err_fatal, i_dbnc_thr, i_hold_cyc, i_err_clr,
    input  o_err_act, o_err_sticky, o_first_id, o_first_vld, o_fst, o_fault, o_pwm_gate,
           o_intb_n, o_fault_cnt
  );

  modport slave (
    input  i_mon_en, i_err_raw, i_err_mask, i_err_fatal, i_dbnc_thr, i_hold_cyc, i_err_clr,
    output o_err_act, o_err_sticky, o_first_id, o_first_vld, o_fst, o_fault, o_pwm_gate,
           o_intb_n, o_fault_cnt
  );

endinterface

// File: rtl/lv_err_dbnc.sv
// One error channel: saturating debounce counter, active flag and write-1-clear sticky bit.
module lv_err_dbnc
  import lv_fault_pkg::*;
#(
  parameter int DBNC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hit,
  input  logic              i_clr,
  input  logic [DBNC_W-1:0] i_thr,
  output logic              o_act,
  output logic              o_sticky,
  output logic              o_sticky_nxt
);

  logic [DBNC_W-1:0] cnt;

  // i_thr is already forced to at least 1, so a cleared counter never reads as active
  assign o_act        = (cnt == i_thr);
  assign o_sticky_nxt = o_act | (o_sticky & ~i_clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      o_sticky <= 1'b0;
    end else begin
      if (!i_hit)             cnt <= '0;
      else if (cnt >= i_thr)  cnt <= i_thr;
      else                    cnt <= cnt + 1'b1;
      o_sticky <= o_sticky_nxt;
    end
  end

endmodule

// File: rtl/lv_fault_mgr.sv
// LV fault manager: per-channel debounce/sticky, first-error capture, monitor FSM with recovery hold-off.
// Define LV_FAULT_MGR_DBG_CNT_EN to build the saturating fault-entry counter on o_fault_cnt.
module lv_fault_mgr
  import lv_fault_pkg::*;
#(
  parameter int ERR_NUM = 16,
  parameter int DBNC_W  = 4,
  parameter int HOLD_W  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lv_fault_mgr_if.slave bus
);

  localparam int ID_W = $clog2(ERR_NUM);

  function automatic logic [ID_W-1:0] lowest_idx(input logic [ERR_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = ERR_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  logic [ERR_NUM-1:0] act, sticky, sticky_nxt;
  logic [DBNC_W-1:0]  thr_eff;
  logic [HOLD_W-1:0]  hold_eff, hold_cnt;
  logic               any_act, fatal_hit;
  fault_st_e          st_q, st_nxt;
  logic               fault_q, pwm_q, intb_q, first_vld_q;
  logic [ID_W-1:0]    first_id_q;

  assign thr_eff   = (bus.i_dbnc_thr == '0) ? DBNC_W'(1) : bus.i_dbnc_thr;
  assign hold_eff  = (bus.i_hold_cyc == '0) ? HOLD_W'(1) : bus.i_hold_cyc;
  assign any_act   = |act;
  assign fatal_hit = |(sticky & bus.i_err_fatal);

  for (genvar g = 0; g < ERR_NUM; g++) begin : g_ch
    lv_err_dbnc #(.DBNC_W(DBNC_W)) u_dbnc (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_hit        (bus.i_err_raw[g] & ~bus.i_err_mask[g] & bus.i_mon_en),
      .i_clr        (bus.i_err_clr[g]),
      .i_thr        (thr_eff),
      .o_act        (act[g]),
      .o_sticky     (sticky[g]),
      .o_sticky_nxt (sticky_nxt[g])
    );
  end

  always_comb begin
    st_nxt = st_q;
    if (!bus.i_mon_en) begin
      st_nxt = IDLE;
    end else begin
      case (st_q)
        IDLE:    st_nxt = MON;
        MON:     if (any_act) st_nxt = FAULT;
        FAULT:   if (!any_act && !fatal_hit) st_nxt = HOLD;
        HOLD:    if (any_act) st_nxt = FAULT;
                 else if (hold_cnt == '0) st_nxt = MON;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Status outputs are registered from next-state / next-sticky so they line up with the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q        <= IDLE;
      hold_cnt    <= '0;
      fault_q     <= 1'b0;
      pwm_q       <= 1'b0;
      intb_q      <= 1'b1;
      first_id_q  <= '0;
      first_vld_q <= 1'b0;
    end else begin
      st_q    <= st_nxt;
      fault_q <= (st_nxt == FAULT);
      pwm_q   <= (st_nxt == FAULT) || (st_nxt == HOLD);
      intb_q  <= ~|(sticky_nxt & ~bus.i_err_mask);
      // Counter holds remaining cycles minus one, so expiry reads as zero on the last HOLD cycle
      if (st_nxt == HOLD && st_q != HOLD) hold_cnt <= hold_eff - 1'b1;
      else if (st_q == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      if (sticky == '0 && sticky_nxt != '0) begin
        first_id_q  <= lowest_idx(act);
        first_vld_q <= 1'b1;
      end else if (sticky_nxt == '0) begin
        first_vld_q <= 1'b0;
      end
    end
  end

`ifdef LV_FAULT_MGR_DBG_CNT_EN
  logic [FAULT_CNT_W-1:0] fault_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_cnt <= '0;
    end else if ((st_q == MON || st_q == HOLD) && st_nxt == FAULT && fault_cnt != '1) begin
      fault_cnt <= fault_cnt + 1'b1;
    end
  end

  assign bus.o_fault_cnt = fault_cnt;
`else
  assign bus.o_fault_cnt = '0;
`endif

  assign bus.o_err_act    = act;
  assign bus.o_err_sticky = sticky;
  assign bus.o_first_id   = first_id_q;
  assign bus.o_first_vld  = first_vld_q;
  assign bus.o_fst        = st_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_pwm_gate   = pwm_q;
  assign bus.o_intb_n     = intb_q;

endmodule

// File: tb/tb_lv_fault_mgr.sv
// Testbench for lv_fault_mgr: vector table, directed corner sequences, randomized run against a reference model.
module tb_lv_fault_mgr;
  import lv_fault_pkg::*;

  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lv_fault_mgr_if #(.ERR_NUM(N), .DBNC_W(4), .HOLD_W(8)) bus ();

  lv_fault_mgr #(.ERR_NUM(N), .DBNC_W(4), .HOLD_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  bit         mon_en_v;
  bit [N-1:0] raw_v, mask_v, fatal_v, clr_v;
  int         thr_v, hold_v;

  // Reference model: run lengths of qualified samples, sticky set, state as integer
  int         run [N];
  bit [N-1:0] m_sticky;
  int         m_st, m_hold_n, m_first, m_cnt;
  bit         m_vld, m_intb;

  typedef struct {
    bit        raw5;
    bit        clr5;
    bit [15:0] act;
    bit [15:0] sticky;
    bit [1:0]  fst;
    bit        fault;
    bit        pwm;
    bit        intb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit [N-1:0] m_act();
    bit [N-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = (run[i] >= eff(thr_v));
    return a;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) run[i] = 0;
    m_sticky = '0; m_st = 0; m_hold_n = 0; m_first = 0; m_cnt = 0; m_vld = 1'b0; m_intb = 1'b1;
  endfunction

  function automatic void model_step();
    bit [N-1:0] a, s;
    int nxt;
    a = m_act();
    s = a | (m_sticky & ~clr_v);
    if (m_sticky == '0 && s != '0) begin
      m_vld = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (a[i]) m_first = i;
    end else if (s == '0) begin
      m_vld = 1'b0;
    end
    if (!mon_en_v)      nxt = 0;
    else if (m_st == 0) nxt = 1;
    else if (m_st == 1) nxt = (a != '0) ? 2 : 1;
    else if (m_st == 2) nxt = (a == '0 && (m_sticky & fatal_v) == '0) ? 3 : 2;
    else                nxt = (a != '0) ? 2 : ((m_hold_n >= eff(hold_v)) ? 1 : 3);
    if (nxt == 3) m_hold_n = (m_st == 3) ? m_hold_n + 1 : 1;
    if ((m_st == 1 || m_st == 3) && nxt == 2 && m_cnt < 255) m_cnt++;
    for (int i = 0; i < N; i++)
      run[i] = (raw_v[i] && !mask_v[i] && mon_en_v) ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
    m_intb   = ((s & ~mask_v) == '0);
    m_sticky = s;
    m_st     = nxt;
  endfunction

  task automatic tick();
    bus.i_mon_en    = mon_en_v;
    bus.i_err_raw   = raw_v;
    bus.i_err_mask  = mask_v;
    bus.i_err_fatal = fatal_v;
    bus.i_err_clr   = clr_v;
    bus.i_dbnc_thr  = 4'(thr_v);
    bus.i_hold_cyc  = 8'(hold_v);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    chk("rnd_act", 32'(bus.o_err_act), 32'(m_act()));
    chk("rnd_sticky", 32'(bus.o_err_sticky), 32'(m_sticky));
    chk("rnd_first_vld", 32'(bus.o_first_vld), 32'(m_vld));
    chk("rnd_first_id", 32'(bus.o_first_id), m_first);
    chk("rnd_fst", 32'(bus.o_fst), m_st);
    chk("rnd_fault", 32'(bus.o_fault), 32'(m_st == 2));
    chk("rnd_pwm", 32'(bus.o_pwm_gate), 32'(m_st >= 2));
    chk("rnd_intb", 32'(bus.o_intb_n), 32'(m_intb));
`ifdef LV_FAULT_MGR_DBG_CNT_EN
    chk("rnd_fault_cnt", 32'(bus.o_fault_cnt), m_cnt);
`else
    chk("rnd_fault_cnt", 32'(bus.o_fault_cnt), 0);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_act"}, 32'(bus.o_err_act), 0);
    chk({tag, "_sticky"}, 32'(bus.o_err_sticky), 0);
    chk({tag, "_first"}, {31'(bus.o_first_id), bus.o_first_vld}, 0);
    chk({tag, "_fst"}, 32'(bus.o_fst), 0);
    chk({tag, "_fault_pwm"}, {30'd0, bus.o_fault, bus.o_pwm_gate}, 0);
    chk({tag, "_intb"}, 32'(bus.o_intb_n), 1);
    chk({tag, "_fault_cnt"}, 32'(bus.o_fault_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit [N-1:0] act_ch, keep;

    //            raw5  clr5  act       sticky    fst   fault pwm   intb
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0020, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0020, 2'd2, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0020, 2'd3, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 2'd3, 1'b0, 1'b1, 1'b1};

    mon_en_v = 1'b0; raw_v = '0; mask_v = '0; fatal_v = '0; clr_v = '0;
    thr_v = 3; hold_v = 10;
    bus.i_mon_en = 1'b0; bus.i_err_raw = '0; bus.i_err_mask = '0; bus.i_err_fatal = '0;
    bus.i_err_clr = '0; bus.i_dbnc_thr = 4'd3; bus.i_hold_cyc = 8'd10;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    mon_en_v = 1'b1;
    tick();
    chk("enter_mon", 32'(bus.o_fst), 1);

    // Debounce, glitch rejection and first fault on channel 5 (thr = 3)
    for (int r = 0; r < 11; r++) begin
      raw_v[5] = tbl[r].raw5;
      clr_v[5] = tbl[r].clr5;
      tick();
      chk($sformatf("tbl%0d_act", r), 32'(bus.o_err_act), 32'(tbl[r].act));
      chk($sformatf("tbl%0d_sticky", r), 32'(bus.o_err_sticky), 32'(tbl[r].sticky));
      chk($sformatf("tbl%0d_fst", r), 32'(bus.o_fst), 32'(tbl[r].fst));
      chk($sformatf("tbl%0d_fault", r), 32'(bus.o_fault), 32'(tbl[r].fault));
      chk($sformatf("tbl%0d_pwm", r), 32'(bus.o_pwm_gate), 32'(tbl[r].pwm));
      chk($sformatf("tbl%0d_intb", r), 32'(bus.o_intb_n), 32'(tbl[r].intb));
    end
    clr_v = '0;
    n = 0;
    while (bus.o_fst != 2'd1 && n < 20) begin tick(); n++; end
    chk("back_to_mon", 32'(bus.o_fst), 1);

    // Recoverable fault on ch2, hold-off of 10 cycles
    thr_v = 1;
    raw_v[2] = 1'b1; tick();
    chk("rec_act2", 32'(bus.o_err_act), 32'h4);
    tick();
    chk("rec_fault", 32'(bus.o_fst), 2);
    chk("rec_first", {31'(bus.o_first_id), bus.o_first_vld}, {31'd2, 1'b1});
    raw_v[2] = 1'b0; tick();
    chk("rec_still_fault", 32'(bus.o_fst), 2);
    tick();
    chk("rec_hold", {30'd0, bus.o_fst}, 3);
    n = 1;
    while (bus.o_fst == 2'd3 && bus.o_pwm_gate && n < 30) begin tick(); if (bus.o_fst == 2'd3) n++; end
    chk("rec_hold_len", n, 10);
    chk("rec_mon", {29'd0, bus.o_fst, bus.o_pwm_gate}, {29'd0, 2'd1, 1'b0});
    chk("rec_sticky_kept", 32'(bus.o_err_sticky), 32'h4);
    clr_v[2] = 1'b1; tick(); clr_v = '0;
    chk("rec_sticky_clr", {31'(bus.o_err_sticky), bus.o_first_vld}, 0);

    // Fatal ch0: set beats clear, exit only once sticky is cleared
    fatal_v[0] = 1'b1; raw_v[0] = 1'b1;
    tick(); tick();
    chk("fat_fault", 32'(bus.o_fst), 2);
    clr_v[0] = 1'b1; tick(); clr_v = '0;
    chk("fat_set_wins", 32'(bus.o_err_sticky), 1);
    raw_v[0] = 1'b0; tick(); tick();
    chk("fat_stays", {30'd0, bus.o_fst}, 2);
    clr_v[0] = 1'b1; tick(); clr_v = '0;
    chk("fat_clr", {31'(bus.o_err_sticky), bus.o_fst == 2'd2}, 1);
    tick();
    chk("fat_hold", 32'(bus.o_fst), 3);

    // Re-fault at HOLD cycle 4, simultaneous ch3/ch7 first errors, later ch1
    tick(); tick();
    raw_v[3] = 1'b1; raw_v[7] = 1'b1; tick();
    chk("rf_hold4", 32'(bus.o_fst), 3);
    tick();
    chk("rf_fault", 32'(bus.o_fst), 2);
    chk("rf_first", {31'(bus.o_first_id), bus.o_first_vld}, {31'd3, 1'b1});
    raw_v = '0; raw_v[1] = 1'b1; tick(); tick();
    chk("rf_sticky", 32'(bus.o_err_sticky), 32'h008A);
    chk("rf_first_held", {31'(bus.o_first_id), bus.o_first_vld}, {31'd3, 1'b1});
    raw_v = '0; clr_v = '1; tick(); tick(); clr_v = '0;
    chk("rf_all_clr", {31'(bus.o_err_sticky), bus.o_first_vld}, 0);
    fatal_v = '0;

    // Mask and monitor disable
    mask_v[9] = 1'b1; raw_v[9] = 1'b1; tick(); tick(); tick();
    chk("mask_no_act", {30'd0, bus.o_err_act[9], bus.o_err_sticky[9]}, 0);
    chk("mask_intb", 32'(bus.o_intb_n), 1);
    mask_v[9] = 1'b0; tick(); tick();
    chk("unmask_fault", 32'(bus.o_fst), 2);
    mon_en_v = 1'b0; tick();
    chk("dis_idle", {29'd0, bus.o_fst, bus.o_pwm_gate}, 0);
    chk("dis_sticky_kept", {30'd0, bus.o_err_sticky[9], bus.o_err_act[9]}, 2);
    chk("dis_intb", 32'(bus.o_intb_n), 0);

    // 300 fault entries for the debug counter
    raw_v = '0; mon_en_v = 1'b1; hold_v = 1; tick(); tick();
    for (int k = 0; k < 300; k++) begin
      raw_v[4] = 1'b1; tick(); tick();
      raw_v[4] = 1'b0; tick(); tick(); tick();
    end
    chk("dbg_mon", 32'(bus.o_fst), 1);
`ifdef LV_FAULT_MGR_DBG_CNT_EN
    chk("dbg_cnt", 32'(bus.o_fault_cnt), 255);
`else
    chk("dbg_cnt", 32'(bus.o_fault_cnt), 0);
`endif

    // Asynchronous reset mid-cycle with sticky bits set
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    model_reset();
    mon_en_v = 1'b0; raw_v = '0; mask_v = '0; clr_v = '0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized run against the reference model
    for (int seg = 0; seg < 15; seg++) begin
      mon_en_v = 1'b0; raw_v = '0; clr_v = '0;
      tick(); check_model();
      thr_v   = $urandom_range(0, 4);
      hold_v  = $urandom_range(0, 6);
      act_ch  = N'($urandom & $urandom);
      mask_v  = N'($urandom & $urandom & $urandom);
      fatal_v = N'($urandom);
      for (int c = 0; c < 200; c++) begin
        mon_en_v = ($urandom_range(0, 49) != 0);
        keep  = N'($urandom | $urandom);
        raw_v = (raw_v & keep) | (N'($urandom) & ~keep & act_ch);
        clr_v = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        if ($urandom_range(0, 19) == 0) begin
          n = $urandom_range(0, N - 1);
          mask_v[n] = ~mask_v[n];
        end
        tick(); check_model();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
